// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the approximate multiplier pipeline.
// Mode encoding, counter width and the truncation bias helper.
package approx_mult_pkg;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_t;

    localparam int CNT_W = 16;

    // Half an LSB of the lowest kept column; zero when nothing is truncated.
    function automatic logic [63:0] bias_const(input int trunc_cols);
        if (trunc_cols <= 0) begin
            return '0;
        end
        return 64'd1 << (trunc_cols - 1);
    endfunction

endpackage

// File: rtl/approx_pp_compress.sv
// Partial-product generation: exact high-row sum plus either the pair-OR compressed
// low rows (approximate) or the exact low-row sum. Purely combinational, no backpressure.
// Latency: 0 cycles.
module approx_pp_compress
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_ROWS = 6,
    parameter int TRUNC_COLS  = 7
) (
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  mode_t              mode,
    output logic [2*WIDTH-1:0] hi_sum,
    output logic [2*WIDTH-1:0] lo_sum
);

    localparam int P       = 2 * WIDTH;
    localparam int ODD_ROW = (APPROX_ROWS > 0) ? APPROX_ROWS - 1 : 0;
    localparam logic [P-1:0] LO_MASK    = (P'(1) << APPROX_ROWS) - P'(1);
    localparam logic [P-1:0] TRUNC_MASK = ~((P'(1) << TRUNC_COLS) - P'(1));

    logic [P-1:0] x_w;
    logic [P-1:0] y_w;
    logic [P-1:0] sel_even;
    logic [P-1:0] sel_odd;
    logic [P-1:0] row_even;
    logic [P-1:0] row_odd;
    logic [P-1:0] approx_sum;
    logic [P-1:0] exact_low;

    always_comb begin
        x_w        = P'(x);
        y_w        = P'(y);
        sel_even   = '0;
        sel_odd    = '0;
        row_even   = '0;
        row_odd    = '0;
        hi_sum     = (y_w * (x_w >> APPROX_ROWS)) << APPROX_ROWS;
        approx_sum = '0;

        // OR of two adjacent rows drops the carry that their sum would produce.
        for (int k = 0; k < APPROX_ROWS / 2; k++) begin
            sel_even   = x_w >> (2 * k);
            sel_odd    = x_w >> (2 * k + 1);
            row_even   = sel_even[0] ? (y_w << (2 * k)) : '0;
            row_odd    = sel_odd[0]  ? (y_w << (2 * k + 1)) : '0;
            approx_sum = approx_sum + ((row_even | row_odd) & TRUNC_MASK);
        end

        if ((APPROX_ROWS % 2) == 1) begin
            sel_even = x_w >> ODD_ROW;
            if (sel_even[0]) begin
                approx_sum = approx_sum + ((y_w << ODD_ROW) & TRUNC_MASK);
            end
        end

        exact_low = y_w * (x_w & LO_MASK);
        lo_sum    = (mode == MODE_APPROX) ? approx_sum : exact_low;
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined approximate/exact unsigned multiplier; optional truncation bias via APPROX_MULT_COMP_EN.
// Latency: 3 cycles accept-to-out_valid, 1 result per cycle.
// Backpressure: global stall when out_valid && !out_ready; in_ready drops in the same cycle.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_ROWS = 6,
    parameter int TRUNC_COLS  = 7,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic               in_approx,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_z,
    output logic [TAG_W-1:0]   out_tag,
    output logic [CNT_W-1:0]   approx_cnt
);

    localparam int P = 2 * WIDTH;

    logic             advance;
    logic             s1_vld;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    mode_t            s1_mode;
    logic [TAG_W-1:0] s1_tag;
    logic [P-1:0]     pp_hi;
    logic [P-1:0]     pp_lo;
    logic             s2_vld;
    logic [P-1:0]     s2_hi;
    logic [P-1:0]     s2_lo;
    logic [TAG_W-1:0] s2_tag;
    logic [P-1:0]     s3_sum;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    approx_pp_compress #(
        .WIDTH       (WIDTH),
        .APPROX_ROWS (APPROX_ROWS),
        .TRUNC_COLS  (TRUNC_COLS)
    ) u_compress (
        .x      (s1_x),
        .y      (s1_y),
        .mode   (s1_mode),
        .hi_sum (pp_hi),
        .lo_sum (pp_lo)
    );

`ifdef APPROX_MULT_COMP_EN
    localparam logic [P-1:0] BIAS = P'(bias_const(TRUNC_COLS));
    mode_t s2_mode;

    assign s3_sum = s2_hi + s2_lo + ((s2_mode == MODE_APPROX) ? BIAS : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_mode <= MODE_EXACT;
        end else if (advance && s1_vld) begin
            s2_mode <= s1_mode;
        end
    end
`else
    assign s3_sum = s2_hi + s2_lo;
`endif

    // Every stage moves together, so bubbles keep their slot during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld     <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_mode    <= MODE_EXACT;
            s1_tag     <= '0;
            s2_vld     <= 1'b0;
            s2_hi      <= '0;
            s2_lo      <= '0;
            s2_tag     <= '0;
            out_valid  <= 1'b0;
            out_z      <= '0;
            out_tag    <= '0;
            approx_cnt <= '0;
        end else begin
            if (advance) begin
                s1_vld <= in_valid;
                if (in_valid) begin
                    s1_x    <= in_x;
                    s1_y    <= in_y;
                    s1_mode <= mode_t'(in_approx);
                    s1_tag  <= in_tag;
                end
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_hi  <= pp_hi;
                    s2_lo  <= pp_lo;
                    s2_tag <= s1_tag;
                end
                out_valid <= s2_vld;
                if (s2_vld) begin
                    out_z   <= s3_sum;
                    out_tag <= s2_tag;
                end
            end
            if (in_valid && advance && in_approx && (approx_cnt != '1)) begin
                approx_cnt <= approx_cnt + CNT_W'(1);
            end
        end
    end

endmodule
